// File: rtl/ccs_i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters.
// Each grant runs a single 16-bit-address register write or read on the camera bus.
module ccs_i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [7:0]  DEV_ADDR       = 8'h6c,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [16*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  busy,
  output logic                  transfer_start,
  output logic                  transfer_continues,
  output logic [7:0]            address,
  output logic [7:0]            data_tx,
  output logic                  bus_clear,
  input  logic                  transfer_ready,
  input  logic                  interrupt,
  input  logic                  nack,
  input  logic                  address_err,
  input  logic [7:0]            data_rx
);

  localparam int unsigned GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  AddrWr = {DEV_ADDR[7:1], 1'b0};
  localparam logic [7:0]  AddrRd = {DEV_ADDR[7:1], 1'b1};
  localparam logic [1:0]  ErrOk = 2'd0, ErrNack = 2'd1, ErrAddr = 2'd2, ErrTimeout = 2'd3;

  typedef enum logic [2:0] {StIdle, StIssue, StMsb, StLsb, StData, StResp} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d, ptr_q, ptr_d, cand;
  logic                 rw_q, rw_d, start_q, start_d, cont_q, cont_d, found;
  logic [15:0]          addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]           address_q, address_d, data_tx_q, data_tx_d;
  logic [1:0]           err_q, err_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 err_hit, timeout_hit;

  // A master nack on the last read byte (address LSB set) is expected and not an error.
  assign err_hit     = interrupt && (address_err || (nack && !address_q[0]));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !interrupt && (cnt_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= ErrOk;
      start_q   <= 1'b0;
      cont_q    <= 1'b0;
      address_q <= AddrWr;
      data_tx_q <= '0;
      cnt_q     <= '0;
      ready_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      start_q   <= start_d;
      cont_q    <= cont_d;
      address_q <= address_d;
      data_tx_q <= data_tx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    start_d   = start_q;
    cont_d    = cont_q;
    address_d = address_q;
    data_tx_d = data_tx_q;
    cnt_d     = cnt_q;
    ready_d   = '0;
    found     = 1'b0;
    cand      = '0;
    case (state_q)
      StIdle: begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          if (!found) begin
            cand = GW'((32'(ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) found = 1'b1;
          end
        end
        if (found) begin
          grant_d        = cand;
          rw_d           = req_rw[cand];
          addr_d         = req_reg_addr[16*cand +: 16];
          wdata_d        = req_wdata[8*cand +: 8];
          rdata_d        = '0;
          err_d          = ErrOk;
          ready_d[cand]  = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        if (transfer_ready) begin
          start_d   = 1'b1;
          cont_d    = 1'b1;
          address_d = AddrWr;
          data_tx_d = addr_q[15:8];
          cnt_d     = '0;
          state_d   = StMsb;
        end
      end
      StMsb, StLsb, StData: begin
        if (err_hit) begin
          start_d = 1'b0;
          cont_d  = 1'b0;
          err_d   = address_err ? ErrAddr : ErrNack;
          state_d = StResp;
        end else if (interrupt) begin
          cnt_d = '0;
          unique case (state_q)
            StMsb: begin
              start_d   = 1'b0;
              cont_d    = !rw_q;
              data_tx_d = addr_q[7:0];
              state_d   = StLsb;
            end
            StLsb: begin
              cont_d = 1'b0;
              if (rw_q) begin
                start_d   = 1'b1;
                address_d = AddrRd;
              end else begin
                start_d   = 1'b0;
                data_tx_d = wdata_q;
              end
              state_d = StData;
            end
            default: begin
              if (rw_q) rdata_d = data_rx;
              start_d = 1'b0;
              state_d = StResp;
            end
          endcase
        end else if (timeout_hit) begin
          start_d = 1'b0;
          cont_d  = 1'b0;
          err_d   = ErrTimeout;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResp: begin
        ptr_d   = GW'((32'(grant_q) + 32'd1) % NUM_REQ);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready          = ready_q;
    rsp_valid          = '0;
    rsp_err            = ErrOk;
    rsp_rdata          = '0;
    bus_clear          = 1'b0;
    busy               = (state_q != StIdle);
    transfer_start     = start_q;
    transfer_continues = cont_q;
    address            = address_q;
    data_tx            = data_tx_q;
    if (state_q == StResp) begin
      rsp_valid[grant_q] = 1'b1;
      rsp_err            = err_q;
      bus_clear          = (err_q == ErrTimeout);
      if (rw_q && err_q == ErrOk) rsp_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_ccs_i2c_arbiter.sv
// Directed bench for ccs_i2c_arbiter; the i2c_master side is driven by hand per byte.
module tb_ccs_i2c_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_rw, req_ready, rsp_valid;
  logic [31:0] req_reg_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata, address, data_tx, data_rx;
  logic [1:0]  rsp_err;
  logic        busy, transfer_start, transfer_continues, bus_clear;
  logic        transfer_ready, interrupt, nack, address_err;

  int errors = 0;
  int checks = 0;

  ccs_i2c_arbiter #(
    .NUM_REQ       (2),
    .DEV_ADDR      (8'hD8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_rw            (req_rw),
    .req_reg_addr      (req_reg_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .busy              (busy),
    .transfer_start    (transfer_start),
    .transfer_continues(transfer_continues),
    .address           (address),
    .data_tx           (data_tx),
    .bus_clear         (bus_clear),
    .transfer_ready    (transfer_ready),
    .interrupt         (interrupt),
    .nack              (nack),
    .address_err       (address_err),
    .data_rx           (data_rx)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic rw, input logic [15:0] a, input logic [7:0] wd);
    req_rw[r]              = rw;
    req_reg_addr[16*r +: 16] = a;
    req_wdata[8*r +: 8]    = wd;
    req_valid[r]           = 1'b1;
  endtask

  task automatic grant_wait(input logic [1:0] exp);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (req_ready == 2'b00 && n < 30);
    check_eq("grant", {30'b0, req_ready}, {30'b0, exp});
  endtask

  task automatic irq(input logic nk, input logic ae, input logic [7:0] rx);
    interrupt   = 1'b1;
    nack        = nk;
    address_err = ae;
    data_rx     = rx;
    @(negedge clk_in);
    interrupt   = 1'b0;
    nack        = 1'b0;
    address_err = 1'b0;
  endtask

  // Runs the three byte phases after a grant; err_stage selects which interrupt carries nack.
  task automatic do_bytes(input int r, input logic rw, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] rx, input int err_stage, input logic ae,
                          input logic [1:0] exp_err);
    logic done;
    logic [7:0] exp_rd;
    @(negedge clk_in);
    check_eq("msb_start", {31'b0, transfer_start}, 32'd1);
    check_eq("msb_cont", {31'b0, transfer_continues}, 32'd1);
    check_eq("msb_addr", {24'b0, address}, 32'hD8);
    check_eq("msb_tx", {24'b0, data_tx}, {24'b0, a[15:8]});
    check_eq("ready_pulse", {30'b0, req_ready}, 32'd0);
    done = 1'b0;
    for (int s = 1; s <= 3 && !done; s++) begin
      repeat (2) @(negedge clk_in);
      irq(s == err_stage, (s == err_stage) && ae, (s == 3) ? rx : 8'h00);
      if (exp_err != 2'd0 && s == err_stage) begin
        done = 1'b1;
      end else if (s == 1) begin
        check_eq("lsb_start", {31'b0, transfer_start}, 32'd0);
        check_eq("lsb_cont", {31'b0, transfer_continues}, {31'b0, ~rw});
        check_eq("lsb_tx", {24'b0, data_tx}, {24'b0, a[7:0]});
      end else if (s == 2) begin
        check_eq("data_cont", {31'b0, transfer_continues}, 32'd0);
        if (rw) begin
          check_eq("rd_restart", {31'b0, transfer_start}, 32'd1);
          check_eq("rd_addr", {24'b0, address}, 32'hD9);
        end else begin
          check_eq("wr_start", {31'b0, transfer_start}, 32'd0);
          check_eq("wr_tx", {24'b0, data_tx}, {24'b0, wd});
        end
      end
    end
    exp_rd = (rw && exp_err == 2'd0) ? rx : 8'h00;
    check_eq("rsp_valid", {30'b0, rsp_valid}, 32'd1 << r);
    check_eq("rsp_err", {30'b0, rsp_err}, {30'b0, exp_err});
    check_eq("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_rd});
    check_eq("rsp_busy", {31'b0, busy}, 32'd1);
    check_eq("rsp_start", {31'b0, transfer_start}, 32'd0);
    check_eq("rsp_cont", {31'b0, transfer_continues}, 32'd0);
    check_eq("rsp_bus_clear", {31'b0, bus_clear}, 32'd0);
    @(negedge clk_in);
    check_eq("rsp_pulse", {30'b0, rsp_valid}, 32'd0);
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset          = 1'b1;
    req_valid      = '0;
    req_rw         = '0;
    req_reg_addr   = '0;
    req_wdata      = '0;
    transfer_ready = 1'b1;
    interrupt      = 1'b0;
    nack           = 1'b0;
    address_err    = 1'b0;
    data_rx        = '0;
    repeat (2) @(negedge clk_in);
    check_eq("rst_addr", {24'b0, address}, 32'hD8);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_start", {31'b0, transfer_start}, 32'd0);
    check_eq("rst_cont", {31'b0, transfer_continues}, 32'd0);
    check_eq("rst_tx", {24'b0, data_tx}, 32'd0);
    check_eq("rst_ready", {30'b0, req_ready}, 32'd0);
    check_eq("rst_rsp", {30'b0, rsp_valid}, 32'd0);
    check_eq("rst_bus_clear", {31'b0, bus_clear}, 32'd0);
    check_eq("rst_err", {30'b0, rsp_err}, 32'd0);
    reset = 1'b0;

    // Write 0x0100 <= 0x01 with transfer_ready held off for a few cycles.
    transfer_ready = 1'b0;
    set_req(0, 1'b0, 16'h0100, 8'h01);
    grant_wait(2'b01);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk_in);
    check_eq("issue_wait", {31'b0, transfer_start}, 32'd0);
    transfer_ready = 1'b1;
    do_bytes(0, 1'b0, 16'h0100, 8'h01, 8'h00, 0, 1'b0, 2'd0);

    // Read 0x300A returns 0x56; nack on the data byte is expected.
    set_req(1, 1'b1, 16'h300A, 8'h00);
    grant_wait(2'b10);
    req_valid[1] = 1'b0;
    do_bytes(1, 1'b1, 16'h300A, 8'h00, 8'h56, 3, 1'b0, 2'd0);

    // Both requesters held: grants alternate 0,1,0,1.
    set_req(0, 1'b0, 16'h1111, 8'h22);
    set_req(1, 1'b0, 16'h3333, 8'h44);
    for (int i = 0; i < 4; i++) begin
      grant_wait((i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 3) req_valid = 2'b00;
      if (i % 2 == 0) do_bytes(0, 1'b0, 16'h1111, 8'h22, 8'h00, 0, 1'b0, 2'd0);
      else            do_bytes(1, 1'b0, 16'h3333, 8'h44, 8'h00, 0, 1'b0, 2'd0);
    end

    // Error paths.
    set_req(0, 1'b0, 16'h0010, 8'hAA);
    grant_wait(2'b01);
    req_valid[0] = 1'b0;
    do_bytes(0, 1'b0, 16'h0010, 8'hAA, 8'h00, 1, 1'b0, 2'd1);
    set_req(1, 1'b1, 16'h0020, 8'h00);
    grant_wait(2'b10);
    req_valid[1] = 1'b0;
    do_bytes(1, 1'b1, 16'h0020, 8'h00, 8'h77, 2, 1'b1, 2'd2);
    set_req(0, 1'b0, 16'h0030, 8'hBB);
    grant_wait(2'b01);
    req_valid[0] = 1'b0;
    do_bytes(0, 1'b0, 16'h0030, 8'hBB, 8'h00, 3, 1'b0, 2'd1);

    // Timeout: no interrupt after start.
    set_req(0, 1'b0, 16'h1234, 8'h55);
    grant_wait(2'b01);
    req_valid[0] = 1'b0;
    @(negedge clk_in);
    check_eq("to_start", {31'b0, transfer_start}, 32'd1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk_in);
      if (bus_clear || rsp_valid != 2'b00) seen = 1'b1;
    end
    check_eq("to_early", {31'b0, seen}, 32'd0);
    @(negedge clk_in);
    check_eq("to_bus_clear", {31'b0, bus_clear}, 32'd1);
    check_eq("to_err", {30'b0, rsp_err}, 32'd3);
    check_eq("to_rsp", {30'b0, rsp_valid}, 32'd1);
    check_eq("to_busy", {31'b0, busy}, 32'd1);
    check_eq("to_start_drop", {31'b0, transfer_start}, 32'd0);
    @(negedge clk_in);
    check_eq("to_busy_fall", {31'b0, busy}, 32'd0);
    check_eq("to_clear_pulse", {31'b0, bus_clear}, 32'd0);

    // Reset during B_LSB aborts silently and resets the round-robin pointer.
    set_req(1, 1'b0, 16'h0203, 8'h04);
    grant_wait(2'b10);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk_in);
    irq(1'b0, 1'b0, 8'h00);
    check_eq("pre_rst_cont", {31'b0, transfer_continues}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_start", {31'b0, transfer_start}, 32'd0);
    check_eq("arst_cont", {31'b0, transfer_continues}, 32'd0);
    check_eq("arst_addr", {24'b0, address}, 32'hD8);
    check_eq("arst_tx", {24'b0, data_tx}, 32'd0);
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    check_eq("arst_rsp", {30'b0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check_eq("arst_no_rsp", {31'b0, seen}, 32'd0);
    set_req(0, 1'b0, 16'h0405, 8'h06);
    set_req(1, 1'b0, 16'h0708, 8'h09);
    grant_wait(2'b01);
    req_valid = 2'b00;
    do_bytes(0, 1'b0, 16'h0405, 8'h06, 8'h00, 0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccs_i2c_arbiter.md
Name: ccs_i2c_arbiter

Overview:
Shares one i2c_master between NUM_REQ independent requesters, such as the sensor bring-up FSM and a runtime exposure/gain writer. Each requester issues a single 16-bit-address camera register access, either an 8-bit write or an 8-bit read. The block grants requesters round-robin and sequences the byte-level i2c_master handshake. It returns a per-requester completion pulse carrying read data and error status.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
DEV_ADDR, 8'h6c, 8-bit sensor bus address; bit 0 is ignored and replaced by the R/W bit.
TIMEOUT_CYCLES, 65535, max clk_in cycles waiting for an i2c_master interrupt; 0 disables the timeout.

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  request pending per requester; held until req_ready
req_rw  input  NUM_REQ  1 = read, 0 = write
req_reg_addr  input  16*NUM_REQ  register address; requester i uses bits [16i+15:16i]
req_wdata  input  8*NUM_REQ  write data; requester i uses bits [8i+7:8i]
req_ready  output  NUM_REQ  one-cycle accept pulse; fields are latched on this cycle
rsp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  output  8  read byte, valid with rsp_valid on a successful read
rsp_err  output  2  0 ok, 1 nack, 2 address_err, 3 timeout; valid with rsp_valid
busy  output  1  high in every state except IDLE
transfer_start, transfer_continues  output  1 each  to i2c_master
address, data_tx  output  8 each  to i2c_master
bus_clear  output  1  to i2c_master; one-cycle pulse on timeout
transfer_ready, interrupt, nack, address_err  input  1 each  from i2c_master
data_rx  input  8  from i2c_master

Behaviour:
- Reset values:
  - All outputs 0, except address = {DEV_ADDR[7:1],0}.
  - State IDLE, RR pointer 0.
  - Reset mid-transaction: no response is issued, and transfer_start/continues drop immediately.
- IDLE:
  - If any req_valid is high, grant the first set bit at or after the RR pointer, wrapping.
  - Latch that requester's rw, addr and wdata.
  - Pulse req_ready[g] and go to ISSUE.
  - A request is never accepted in the same cycle as a rsp_valid.
- ISSUE:
  - Wait for transfer_ready. Interrupt is ignored in this state.
  - When transfer_ready: drive transfer_start=1, continues=1, address={DEV_ADDR[7:1],0}, data_tx=addr[15:8]. Go to B_MSB.
- B_MSB, on interrupt:
  - Error check first (see error rule).
  - Otherwise: transfer_start=0, continues=!rw, data_tx=addr[7:0]. Go to B_LSB.
- B_LSB, on interrupt:
  - Error check.
  - Write: transfer_start=0, continues=0, data_tx=wdata.
  - Read: transfer_start=1 (repeated start), continues=0, address={DEV_ADDR[7:1],1}.
  - Go to B_DATA.
- B_DATA, on interrupt:
  - Error check. Nack is ignored when address[0]=1, because a master nack on the final read byte is expected.
  - Capture data_rx if reading. transfer_start=0. Go to RESP.
- Error rule:
  - Applies on interrupt with address_err=1, or with nack=1 and address[0]=0.
  - Action: transfer_start=0, continues=0, rsp_err = 2 if address_err else 1. Go to RESP.
  - address_err takes precedence over nack.
- Timeout:
  - A counter resets on entry to each of B_MSB, B_LSB and B_DATA, and counts while no interrupt arrives.
  - At TIMEOUT_CYCLES: pulse bus_clear for 1 cycle, transfer_start=0, continues=0, rsp_err=3. Go to RESP.
  - An interrupt arriving in the same cycle as the expiry wins; no timeout is declared.
- Signal hold rule: transfer_start, continues, address and data_tx are registered and held until the next interrupt or state change.
- RESP:
  - Pulse rsp_valid[g] for one cycle with rsp_err. rsp_rdata = captured byte on a successful read, else 0.
  - RR pointer = (g+1) mod NUM_REQ. Return to IDLE.
- Latency: req_ready is 1 cycle after req_valid seen in IDLE; rsp_valid is 1 cycle after the final interrupt.
- Fairness: a requester with a continuously held req_valid waits at most NUM_REQ-1 transactions.
- Requester deasserts req_valid before req_ready: no effect unless already granted. Once granted, the transaction always completes.

Test Plan:
- Req0 write 0x0100<=0x01, i2c model acks → data_tx sequence 0x01, 0x00, 0x01; address 0xD8; rsp_valid[0], rsp_err=0.
- Req1 read 0x300A, model returns 0x56 → restart with address 0xD9 at the 2nd interrupt; rsp_rdata=0x56, rsp_err=0; nack on the data byte is ignored.
- Both req_valid held, 4 transactions → grants 0,1,0,1; each req_ready is a single-cycle pulse.
- Nack at the 1st interrupt of a write → rsp_err=1 with no further bytes; address_err+nack together → rsp_err=2.
- TIMEOUT_CYCLES=16, model never interrupts after start → bus_clear pulse 16 cycles after B_MSB entry, rsp_err=3, busy falls the next cycle.
- Assert reset during B_LSB → all outputs 0 asynchronously, no rsp_valid; the next request proceeds normally with grant to requester 0.
